pipeline_hazard_unit: RTL
=========================

// Module: pipeline_hazard_unit
// PURPOSE
//  Issuing end of the stall/flush interface driven into the 5-stage (F/D/E/M/W) ARM pipeline control unit and datapath.
//  Resolves data hazards by forwarding into E, load-use stalls, and PC-write and branch flushes.
//  Adds a data-memory wait FSM that freezes F..M while a memory access in M is not ready, with a timeout error.
//  Keeps saturating stall and flush event counters for performance debug.
// PARAMETERS
//  CNT_W        16   width of the StallCycles / FlushEvents counters
//  MEM_TIMEOUT  64   wait cycles in WAIT before MemErr sets (>=1)
// PORTS
//  clk          in   1      pipeline clock; all state updates on the rising edge
//  reset        in   1      synchronous, active-high
//  RA1D,RA2D    in   4      source registers of the instruction in D
//  RA1E,RA2E    in   4      source registers of the instruction in E
//  WA3E,WA3M,WA3W in 4      destination registers in E/M/W
//  RegWriteM,RegWriteW in 1 register write enables in M/W
//  MemtoRegE    in   1      the instruction in E is a load
//  PCW_DEM      in   1      PC write pending in D, E or M
//  PCSrcW       in   1      PC write in W
//  BranchTakenE in   1      branch resolved as taken in E
//  MemAccessM   in   1      M holds a data-memory load or store
//  MemReadyM    in   1      data memory has completed the access this cycle
//  ForwardAE,ForwardBE out 2  00 regfile, 01 ResultW, 10 ALUOutM
//  StallF,StallD,StallE,StallM out 1  hold the pipeline register feeding that stage
//  FlushD,FlushE,FlushW out 1  bubble into that stage's pipeline register
//  MemErr       out  1      sticky: memory wait exceeded MEM_TIMEOUT
//  StallCycles  out CNT_W   saturating count of cycles with any stall asserted
//  FlushEvents  out CNT_W   saturating count of cycles with FlushD or FlushE asserted
// BEHAVIOUR
//  Reset (cycle with reset=1):
//   - state=IDLE; wait counter=0; MemErr=0; counters=0.
//   - Outputs forced: all Stall*=0, FlushD=FlushE=FlushW=1, Forward*=00.
//  Forwarding (combinational, every cycle):
//   - ForwardAE=10 if RegWriteM && WA3M==RA1E.
//   - Otherwise ForwardAE=01 if RegWriteW && WA3W==RA1E.
//   - Otherwise ForwardAE=00. ForwardBE is the same with RA2E.
//   - M has priority over W. R15 is not excluded.
//  Hazard terms in IDLE:
//   - ldrStall = MemtoRegE && (WA3E==RA1D || WA3E==RA2D).
//   - StallF = ldrStall || PCW_DEM.
//   - StallD = ldrStall.
//   - FlushD = PCW_DEM || PCSrcW || BranchTakenE.
//   - FlushE = ldrStall || BranchTakenE.
//   - StallE = StallM = FlushW = 0.
//  Memory wait FSM (states IDLE, WAIT, 1-bit register):
//   - IDLE->WAIT when MemAccessM && !MemReadyM. This cycle already uses the WAIT outputs (Mealy).
//   - In WAIT: StallF=StallD=StallE=StallM=1, FlushD=FlushE=0, FlushW=1.
//   - All D/E hazard flushes are deferred: stalled registers hold, so BranchTakenE/ldrStall reappear after release.
//   - WAIT->IDLE in the cycle MemReadyM=1. That cycle uses the IDLE equations and FlushW=0.
//   - Wait counter: 0 in IDLE; +1 per cycle in WAIT.
//   - When it reaches MEM_TIMEOUT, MemErr sets on that edge. The FSM stays in WAIT.
//   - MemErr clears only on reset.
//   - Reset mid-WAIT: the next cycle is IDLE with reset outputs. No stale stall.
//  Counters:
//   - StallCycles +1 on each edge where any Stall* output was 1.
//   - FlushEvents +1 on each edge where FlushD||FlushE was 1.
//   - Neither counts during reset. Both saturate at all-ones (no wrap).
//  Latency: all stall/flush/forward outputs are combinational from inputs+state, valid in the same cycle.
// TESTING
//  - RegWriteM=1,WA3M=3,RA1E=3, RegWriteW=1,WA3W=3 -> ForwardAE=10; with RegWriteM=0 -> 01; RA1E=4 -> 00.
//  - MemtoRegE=1,WA3E=5,RA2D=5 -> StallF=StallD=FlushE=1, FlushD=0; StallCycles increments by 1.
//  - BranchTakenE=1 for one cycle -> FlushD=FlushE=1, no stalls; FlushEvents +1.
//  - PCW_DEM=1 for 3 cycles then PCSrcW=1 -> StallF=FlushD=1 for 3 cycles, then FlushD=1,StallF=0.
//  - MemAccessM=1,MemReadyM=0 for 4 cycles, then ready -> StallF..M=1,FlushW=1 for 4 cycles; idle outputs on the ready cycle.
//  - MEM_TIMEOUT=8, ready never asserted -> MemErr=1 after the 8th wait edge.
//  - Follow-up case: reset mid-WAIT -> IDLE, MemErr=0, counters=0.
//  - Saturation, CNT_W=4, stall held for 20 cycles -> StallCycles stops at 15.

Source files
------------

// File: rtl/pipeline_hazard_unit.sv
// Hazard unit for the 5-stage pipeline: forwarding into E, load-use stall, PC/branch flushes,
// a data-memory wait FSM with a timeout error, and saturating stall/flush event counters.
module pipeline_hazard_unit #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCW_DEM,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    input  logic             MemAccessM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushEvents
);

    localparam int                WCNT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic              ldr_stall_s;
    logic              mem_wait_s;
    logic              any_stall_s;
    logic              any_flush_s;

    // Forward source select: the younger producer in M wins over W.
    function automatic logic [1:0] fwd_sel(
        input logic       we_m,
        input logic [3:0] wa_m,
        input logic       we_w,
        input logic [3:0] wa_w,
        input logic [3:0] ra
    );
        logic [1:0] sel;
        if (we_m && (wa_m == ra)) begin
            sel = 2'b10;
        end else if (we_w && (wa_w == ra)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Forwarding muxes for both E-stage operands.
    always_comb begin
        if (reset) begin
            ForwardAE = 2'b00;
            ForwardBE = 2'b00;
        end else begin
            ForwardAE = fwd_sel(RegWriteM, WA3M, RegWriteW, WA3W, RA1E);
            ForwardBE = fwd_sel(RegWriteM, WA3M, RegWriteW, WA3W, RA2E);
        end
    end

    // Stall/flush generation; the memory wait is Mealy so the entry cycle already freezes F..M.
    always_comb begin
        ldr_stall_s = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
        if (state_q == ST_WAIT) begin
            mem_wait_s = !MemReadyM;
        end else begin
            mem_wait_s = MemAccessM && !MemReadyM;
        end

        if (reset) begin
            StallF = 1'b0;
            StallD = 1'b0;
            StallE = 1'b0;
            StallM = 1'b0;
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (mem_wait_s) begin
            // D/E flushes are deferred; held registers re-raise them once memory releases.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b1;
        end else begin
            StallF = ldr_stall_s || PCW_DEM;
            StallD = ldr_stall_s;
            StallE = 1'b0;
            StallM = 1'b0;
            FlushD = PCW_DEM || PCSrcW || BranchTakenE;
            FlushE = ldr_stall_s || BranchTakenE;
            FlushW = 1'b0;
        end

        any_stall_s = StallF || StallD || StallE || StallM;
        any_flush_s = FlushD || FlushE;
    end

    // Next-state for the wait FSM, timeout counter and sticky error.
    always_comb begin
        if (mem_wait_s) begin
            state_d = ST_WAIT;
            if (wait_cnt_q == WCNT_MAX) begin
                wait_cnt_d = wait_cnt_q;
            end else begin
                wait_cnt_d = wait_cnt_q + WCNT_W'(1);
            end
        end else begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
        end

        if (mem_wait_s && (wait_cnt_d == WCNT_MAX)) begin
            mem_err_d = 1'b1;
        end else begin
            mem_err_d = mem_err_q;
        end
    end

    // Saturating performance counters.
    always_comb begin
        if (any_stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        if (any_flush_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign MemErr      = mem_err_q;
    assign StallCycles = stall_cnt_q;
    assign FlushEvents = flush_cnt_q;

endmodule
